// File: rtl/alu_pkg.sv
// Shared opcode definitions for the execute-stage ALU.
package alu_pkg;

    localparam int ALU_SEL_W = 4;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'b0010;
    localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR = 4'b0100;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor sharing one carry chain.
// Subtraction is a + ~b + ~cin; the carry out is inverted so that c reports
// a borrow (unsigned a < b + cin) rather than a carry.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int BUS_SIZE = 32
) (
    input  logic [BUS_SIZE-1:0] a,
    input  logic [BUS_SIZE-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic [BUS_SIZE-1:0] sum,
    output logic                c
);

    logic [BUS_SIZE-1:0] bOp;
    logic                cinOp;
    logic [BUS_SIZE:0]   total;

    // Condition operand and carry-in, then add in BUS_SIZE+1 bits so the MSB is the carry.
    always_comb begin
        bOp   = sub ? ~b : b;
        cinOp = sub ? ~cin : cin;
        total = {1'b0, a} + {1'b0, bOp} + {{BUS_SIZE{1'b0}}, cinOp};
        sum   = total[BUS_SIZE-1:0];
        c     = total[BUS_SIZE] ^ sub;
    end

endmodule

// File: rtl/alu.sv
// Registered 32-bit integer ALU for the MIPS32 execute stage.
// One-cycle latency, no handshake: a new operation may be issued every cycle.
module alu
    import alu_pkg::*;
#(
    parameter int BUS_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_SIZE-1:0]  A,
    input  logic [BUS_SIZE-1:0]  B,
    input  logic [ALU_SEL_W-1:0] selector,
    input  logic                 carryIn,
    output logic [BUS_SIZE-1:0]  R,
    output logic                 flagZ,
    output logic                 flagN,
    output logic                 flagC
);

    logic [BUS_SIZE-1:0] arithSum;
    logic                arithCarry;
    logic                isSub;
    logic [BUS_SIZE-1:0] resNext;
    logic                carryNext;
    logic                zeroNext;
    logic                negNext;

    assign isSub = (selector == ALU_SUB);

    alu_addsub #(
        .BUS_SIZE(BUS_SIZE)
    ) uAddSub (
        .a   (A),
        .b   (B),
        .cin (carryIn),
        .sub (isSub),
        .sum (arithSum),
        .c   (arithCarry)
    );

    // Operation mux; unused codes yield zero result and clear carry.
    always_comb begin
        resNext   = '0;
        carryNext = 1'b0;
        case (selector)
            ALU_ADD, ALU_SUB: begin
                resNext   = arithSum;
                carryNext = arithCarry;
            end
            ALU_AND: resNext = A & B;
            ALU_OR:  resNext = A | B;
            ALU_XOR: resNext = A ^ B;
            default: begin
                resNext   = '0;
                carryNext = 1'b0;
            end
        endcase
        zeroNext = (resNext == '0);
        negNext  = resNext[BUS_SIZE-1];
    end

    // Output register bank; reset clears result and all flags (flagZ included).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R     <= '0;
            flagZ <= 1'b0;
            flagN <= 1'b0;
            flagC <= 1'b0;
        end else begin
            R     <= resNext;
            flagZ <= zeroNext;
            flagN <= negNext;
            flagC <= carryNext;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the registered ALU: expected results are queued when
// an operation is driven and compared one clock edge later.
module tb_alu;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [3:0]    selector;
    logic          carryIn;
    logic [W-1:0]  R;
    logic          flagZ;
    logic          flagN;
    logic          flagC;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         n;
        logic         c;
    } expT;

    expT   expQ[$];
    string tagQ[$];
    int    checks = 0;
    int    errors = 0;

    alu #(.BUS_SIZE(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .selector (selector),
        .carryIn  (carryIn),
        .R        (R),
        .flagZ    (flagZ),
        .flagN    (flagN),
        .flagC    (flagC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference: plain wide arithmetic and a direct borrow comparison.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                         input logic cin, output logic [W-1:0] r, output logic c);
        logic [63:0] wide;
        r = '0;
        c = 1'b0;
        case (sel)
            4'd0: begin
                wide = 64'(a) + 64'(b) + 64'(cin);
                r = wide[W-1:0];
                c = wide[W];
            end
            4'd1: begin
                r = a - b - W'(cin);
                c = (64'(a) < (64'(b) + 64'(cin)));
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: begin
                r = '0;
                c = 1'b0;
            end
        endcase
    endtask

    // Apply inputs now and queue the expected result; Z and N follow from R.
    task automatic setOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                         input logic cin, input logic [W-1:0] expR, input logic expC, input string tag);
        expT e;
        A        = a;
        B        = b;
        selector = sel;
        carryIn  = cin;
        e.r = expR;
        e.z = (expR == '0);
        e.n = expR[W-1];
        e.c = expC;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                         input logic cin, input logic [W-1:0] expR, input logic expC, input string tag);
        @(negedge clk);
        setOp(a, b, sel, cin, expR, expC, tag);
    endtask

    task automatic driveModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                              input logic cin, input string tag);
        logic [W-1:0] r;
        logic         c;
        model(a, b, sel, cin, r, c);
        drive(a, b, sel, cin, r, c, tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        checkVal("drain", 64'(expQ.size()), 64'd0);
    endtask

    // Monitor: each queued operation is visible just after the following rising edge.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            expT   e;
            string t;
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkVal({t, ".R"}, 64'(R), 64'(e.r));
            checkVal({t, ".Z"}, 64'(flagZ), 64'(e.z));
            checkVal({t, ".N"}, 64'(flagN), 64'(e.n));
            checkVal({t, ".C"}, 64'(flagC), 64'(e.c));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        A        = '0;
        B        = '0;
        selector = '0;
        carryIn  = 1'b0;
        #3;
        checkVal("rst0.R", 64'(R), 64'd0);
        checkVal("rst0.Z", 64'(flagZ), 64'd0);
        checkVal("rst0.N", 64'(flagN), 64'd0);
        checkVal("rst0.C", 64'(flagC), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // A=10, B=10
        drive(32'd10, 32'd10, 4'b0000, 1'b0, 32'd20, 1'b0, "t10.add");
        drive(32'd10, 32'd10, 4'b0001, 1'b0, 32'd0,  1'b0, "t10.sub");
        drive(32'd10, 32'd10, 4'b0010, 1'b0, 32'd10, 1'b0, "t10.and");
        drive(32'd10, 32'd10, 4'b0011, 1'b0, 32'd10, 1'b0, "t10.or");
        drive(32'd10, 32'd10, 4'b0100, 1'b0, 32'd0,  1'b0, "t10.xor");
        drive(32'd10, 32'd10, 4'b0101, 1'b0, 32'd0,  1'b0, "t10.u5");
        drive(32'd10, 32'd10, 4'b0110, 1'b0, 32'd0,  1'b0, "t10.u6");
        drive(32'd10, 32'd10, 4'b0111, 1'b0, 32'd0,  1'b0, "t10.u7");

        // A=100, B=-5
        drive(32'd100, 32'hFFFF_FFFB, 4'b0000, 1'b0, 32'd95,         1'b1, "neg.add");
        drive(32'd100, 32'hFFFF_FFFB, 4'b0001, 1'b0, 32'd105,        1'b1, "neg.sub");
        drive(32'd100, 32'hFFFF_FFFB, 4'b0010, 1'b0, 32'h0000_0060,  1'b0, "neg.and");
        drive(32'd100, 32'hFFFF_FFFB, 4'b0011, 1'b0, 32'hFFFF_FFFF,  1'b0, "neg.or");
        drive(32'd100, 32'hFFFF_FFFB, 4'b0100, 1'b0, 32'hFFFF_FF9F,  1'b0, "neg.xor");

        // A=5, B=15
        drive(32'd5, 32'd15, 4'b0000, 1'b0, 32'd20,         1'b0, "small.add");
        drive(32'd5, 32'd15, 4'b0001, 1'b0, 32'hFFFF_FFF6,  1'b1, "small.sub");
        drive(32'd5, 32'd15, 4'b0010, 1'b0, 32'd5,          1'b0, "small.and");
        drive(32'd5, 32'd15, 4'b0011, 1'b0, 32'd15,         1'b0, "small.or");
        drive(32'd5, 32'd15, 4'b0100, 1'b0, 32'd10,         1'b0, "small.xor");

        // carryIn = 1
        drive(32'hFFFF_FFFF, 32'd0, 4'b0000, 1'b1, 32'd0,         1'b1, "cin.add");
        drive(32'd5,         32'd5, 4'b0001, 1'b1, 32'hFFFF_FFFF, 1'b1, "cin.sub");
        drive(32'd9,         32'hFFFF_FFFF, 4'b0001, 1'b1, 32'd9, 1'b1, "cin.subwrap");
        drive(32'd7,         32'd3, 4'b0000, 1'b1, 32'd11,        1'b0, "cin.add2");

        // unused codes 1xxx, carryIn ignored
        drive(32'd7, 32'd3, 4'b1000, 1'b0, 32'd0, 1'b0, "u8");
        drive(32'd7, 32'd3, 4'b1111, 1'b1, 32'd0, 1'b0, "u15");

        // load a nonzero value, then reset mid-cycle
        drive(32'd10, 32'd10, 4'b0000, 1'b0, 32'd20, 1'b0, "prerst.add");
        drain();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("rst1.R", 64'(R), 64'd0);
        checkVal("rst1.Z", 64'(flagZ), 64'd0);
        checkVal("rst1.N", 64'(flagN), 64'd0);
        checkVal("rst1.C", 64'(flagC), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        setOp(32'd100, 32'hFFFF_FFFB, 4'b0100, 1'b0, 32'hFFFF_FF9F, 1'b0, "postrst.xor");

        // back-to-back random operations, one per cycle
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [3:0]   sel;
            logic         cin;
            a   = $urandom;
            b   = (i % 4 == 0) ? a : $urandom;
            sel = (i % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            cin = 1'($urandom_range(0, 1));
            driveModel(a, b, sel, cin, "rand");
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
